// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side signals of the CHIP-8 memory arbiter.
// Latency: n/a (wiring only). Backpressure: requesters hold req until ack; memory paces reads via mem_read_ack.
// Ports: req/we/addrN/wdataN in, ack/rdata/busy/grant_id out; mem_read*/mem_write* to memory, mem_read_data/ack back.
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic [2:0]            req;
  logic [2:0]            we;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [ADDR_WIDTH-1:0] addr2;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic [DATA_WIDTH-1:0] wdata2;
  logic [2:0]            ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic [1:0]            grant_id;
  logic                  mem_read;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  mem_read_ack;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;

  // Requesters plus memory: drive requests and memory responses.
  modport master (
    output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2,
    output mem_read_data, mem_read_ack,
    input  ack, rdata, busy, grant_id,
    input  mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data
  );

  // Arbiter side.
  modport slave (
    input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2,
    input  mem_read_data, mem_read_ack,
    output ack, rdata, busy, grant_id,
    output mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one CHIP-8 memory (read port + write port) among CPU, display, loader.
// Latency: write ack 2 cycles after IDLE sample, read ack 3 cycles plus memory stall; one transaction in flight.
// Backpressure: requesters hold req until their one-cycle ack; reads wait indefinitely for mem_read_ack.
// Ports: clk, reset (sync, active-high), bus (mem_arbiter_if.slave) carrying requester and memory signals.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                r_state;
  logic [1:0]            r_grant_id;
  logic                  r_we;
  logic [2:0]            r_ack;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_busy;
  logic                  r_mem_read;
  logic [ADDR_WIDTH-1:0] r_mem_read_addr;
  logic                  r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_write_addr;
  logic [DATA_WIDTH-1:0] r_mem_write_data;

  logic                  w_any;
  logic [1:0]            w_winner;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  // Round-robin pick: search begins one past the last grant, wrapping at 3.
  always_comb begin
    w_any    = |bus.req;
    w_winner = r_grant_id;
    case (r_grant_id)
      2'd0: begin
        if      (bus.req[1]) w_winner = 2'd1;
        else if (bus.req[2]) w_winner = 2'd2;
        else if (bus.req[0]) w_winner = 2'd0;
      end
      2'd1: begin
        if      (bus.req[2]) w_winner = 2'd2;
        else if (bus.req[0]) w_winner = 2'd0;
        else if (bus.req[1]) w_winner = 2'd1;
      end
      default: begin
        if      (bus.req[0]) w_winner = 2'd0;
        else if (bus.req[1]) w_winner = 2'd1;
        else if (bus.req[2]) w_winner = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_we    = bus.we[2];
    w_addr  = bus.addr2;
    w_wdata = bus.wdata2;
    case (w_winner)
      2'd0: begin
        w_we    = bus.we[0];
        w_addr  = bus.addr0;
        w_wdata = bus.wdata0;
      end
      2'd1: begin
        w_we    = bus.we[1];
        w_addr  = bus.addr1;
        w_wdata = bus.wdata1;
      end
      default: begin
        w_we    = bus.we[2];
        w_addr  = bus.addr2;
        w_wdata = bus.wdata2;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_grant_id       <= 2'd2;
      r_we             <= 1'b0;
      r_ack            <= '0;
      r_rdata          <= '0;
      r_busy           <= 1'b0;
      r_mem_read       <= 1'b0;
      r_mem_read_addr  <= '0;
      r_mem_write      <= 1'b0;
      r_mem_write_addr <= '0;
      r_mem_write_data <= '0;
    end else begin
      // Strobes and ack are single-cycle pulses by default.
      r_ack       <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            // Strobe is loaded here so it is visible exactly during ISSUE.
            r_grant_id <= w_winner;
            r_we       <= w_we;
            if (w_we) begin
              r_mem_write      <= 1'b1;
              r_mem_write_addr <= w_addr;
              r_mem_write_data <= w_wdata;
            end else begin
              r_mem_read      <= 1'b1;
              r_mem_read_addr <= w_addr;
            end
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_we) begin
            r_ack   <= 3'b001 << r_grant_id;
            r_state <= DONE;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_read_ack) begin
            r_rdata <= bus.mem_read_data;
            r_ack   <= 3'b001 << r_grant_id;
            r_state <= DONE;
          end
        end
        // Requests are deliberately not sampled here, so a requester still
        // holding req right after its ack is not served twice.
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack            = r_ack;
  assign bus.rdata          = r_rdata;
  assign bus.busy           = r_busy;
  assign bus.grant_id       = r_grant_id;
  assign bus.mem_read       = r_mem_read;
  assign bus.mem_read_addr  = r_mem_read_addr;
  assign bus.mem_write      = r_mem_write;
  assign bus.mem_write_addr = r_mem_write_addr;
  assign bus.mem_write_data = r_mem_write_data;

endmodule
